// File: rtl/pio_pkg.sv
// Shared PIO definitions: opcodes, instruction field widths and side-set/delay split helpers.
package pio_pkg;

    localparam int OP_W      = 3;
    localparam int FIELD_W   = 5;
    localparam int OP1_W     = 3;
    localparam int OP2_W     = 5;
    localparam int SS_CFG_W  = 3;

    typedef enum logic [2:0] {
        OP_JMP       = 3'd0,
        OP_WAIT      = 3'd1,
        OP_IN        = 3'd2,
        OP_OUT       = 3'd3,
        OP_PUSH_PULL = 3'd4,
        OP_MOV       = 3'd5,
        OP_IRQ       = 3'd6,
        OP_SET       = 3'd7
    } pio_op_e;

    function automatic logic [2:0] sideset_clamp(input logic [2:0] sideset_bits);
        return (sideset_bits > 3'd5) ? 3'd5 : sideset_bits;
    endfunction

    // Bits of the shared [12:8] field left over for the delay count.
    function automatic logic [2:0] delay_bits(input logic [2:0] sideset_bits);
        return 3'd5 - sideset_clamp(sideset_bits);
    endfunction

endpackage

// File: rtl/pio_field_pack.sv
// Combinational PIO instruction packing with side-set/delay truncation checks.
// Range checks exist only when PIO_INSTR_ENCODER_CHECK_EN is defined; otherwise flags read 0.
module pio_field_pack
    import pio_pkg::*;
(
    input  logic [SS_CFG_W-1:0] sideset_bits,
    input  logic                sideset_enable_bit,
    input  logic [OP_W-1:0]     s_op,
    input  logic [OP1_W-1:0]    s_op1,
    input  logic [OP2_W-1:0]    s_op2,
    input  logic [FIELD_W-1:0]  s_delay,
    input  logic [FIELD_W-1:0]  s_side_set,
    input  logic                s_side_en,
    output logic [15:0]         instr,
    output logic                delay_ovf,
    output logic                side_ovf,
    output logic                cfg_err
);

    logic [2:0]         sb;
    logic [2:0]         db;
    logic [2:0]         dw;
    logic               en;
    logic [FIELD_W-1:0] delay_mask;
    logic [FIELD_W-1:0] side_mask;
    logic [FIELD_W-1:0] delay_trunc;
    logic [FIELD_W-1:0] side_trunc;
    logic [FIELD_W-1:0] field;

    always_comb begin
        sb          = sideset_clamp(sideset_bits);
        db          = delay_bits(sideset_bits);
        en          = sideset_enable_bit & (sb != 3'd0);
        dw          = sb - {2'b00, en};
        delay_mask  = 5'((6'd1 << db) - 6'd1);
        side_mask   = 5'((6'd1 << dw) - 6'd1);
        delay_trunc = s_delay & delay_mask;
        side_trunc  = s_side_set & side_mask;
        field       = (side_trunc << db) | delay_trunc;
        // Side-set data never reaches bit 4 when the enable flag is in use.
        if (en) begin
            field[4] = s_side_en;
        end
        instr = {s_op, field, s_op1, s_op2};
    end

`ifdef PIO_INSTR_ENCODER_CHECK_EN
    assign delay_ovf = (s_delay & ~delay_mask) != 5'd0;
    assign side_ovf  = (s_side_set & ~side_mask) != 5'd0;
    assign cfg_err   = sideset_enable_bit & (sb == 3'd0);
`else
    assign delay_ovf = 1'b0;
    assign side_ovf  = 1'b0;
    assign cfg_err   = 1'b0;
`endif

endmodule

// File: rtl/pio_instr_encoder.sv
// Streams packed PIO instructions into instruction memory with auto-incrementing address.
// Sticky truncation flags are live only when PIO_INSTR_ENCODER_CHECK_EN is defined.
module pio_instr_encoder
    import pio_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         sideset_bits,
    input  logic               sideset_enable_bit,
    input  logic               load_addr,
    input  logic [ADDR_W-1:0]  load_value,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [2:0]         s_op,
    input  logic [2:0]         s_op1,
    input  logic [4:0]         s_op2,
    input  logic [4:0]         s_delay,
    input  logic [4:0]         s_side_set,
    input  logic               s_side_en,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [ADDR_W-1:0]  m_addr,
    output logic [INSTR_W-1:0] m_data,
    output logic [5:0]         count,
    output logic               err_delay,
    output logic               err_side,
    output logic               err_cfg
);

    logic [15:0]        packed_word;
    logic               delay_ovf, side_ovf, cfg_err;
    logic               accept, xfer;
    logic [ADDR_W-1:0]  addr_sel;

    logic               m_valid_q, m_valid_d;
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic [INSTR_W-1:0] m_data_q, m_data_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [5:0]         count_q, count_d;
    logic               err_delay_q, err_delay_d;
    logic               err_side_q, err_side_d;
    logic               err_cfg_q, err_cfg_d;

    pio_field_pack u_pack (
        .sideset_bits       (sideset_bits),
        .sideset_enable_bit (sideset_enable_bit),
        .s_op               (s_op),
        .s_op1              (s_op1),
        .s_op2              (s_op2),
        .s_delay            (s_delay),
        .s_side_set         (s_side_set),
        .s_side_en          (s_side_en),
        .instr              (packed_word),
        .delay_ovf          (delay_ovf),
        .side_ovf           (side_ovf),
        .cfg_err            (cfg_err)
    );

    assign s_ready = !m_valid_q | m_ready;
    assign accept  = s_valid & s_ready;
    assign xfer    = m_valid_q & m_ready;
    assign addr_sel = load_addr ? load_value : wr_addr_q;

    always_comb begin
        m_valid_d   = m_valid_q;
        m_addr_d    = m_addr_q;
        m_data_d    = m_data_q;
        wr_addr_d   = wr_addr_q;
        count_d     = count_q;
        err_delay_d = err_delay_q;
        err_side_d  = err_side_q;
        err_cfg_d   = err_cfg_q;

        if (xfer) begin
            m_valid_d = 1'b0;
            if (count_q != 6'd63) begin
                count_d = count_q + 6'd1;
            end
        end

        if (accept) begin
            m_valid_d   = 1'b1;
            m_addr_d    = addr_sel;
            m_data_d    = INSTR_W'(packed_word);
            wr_addr_d   = addr_sel + 1'b1;
            err_delay_d = err_delay_q | delay_ovf;
            err_side_d  = err_side_q | side_ovf;
            err_cfg_d   = err_cfg_q | cfg_err;
        end else if (load_addr) begin
            // Parked in the write pointer; the held output word is untouched.
            wr_addr_d = load_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_valid_q   <= 1'b0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            wr_addr_q   <= '0;
            count_q     <= '0;
            err_delay_q <= 1'b0;
            err_side_q  <= 1'b0;
            err_cfg_q   <= 1'b0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_addr_q    <= m_addr_d;
            m_data_q    <= m_data_d;
            wr_addr_q   <= wr_addr_d;
            count_q     <= count_d;
            err_delay_q <= err_delay_d;
            err_side_q  <= err_side_d;
            err_cfg_q   <= err_cfg_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_addr    = m_addr_q;
    assign m_data    = m_data_q;
    assign count     = count_q;
    assign err_delay = err_delay_q;
    assign err_side  = err_side_q;
    assign err_cfg   = err_cfg_q;

endmodule

// File: tb/tb_pio_instr_encoder.sv
// Directed and randomised checks of pio_instr_encoder against an arithmetic reference and a word scoreboard.
module tb_pio_instr_encoder;
    import pio_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [2:0]  sideset_bits;
    logic        sideset_enable_bit;
    logic        load_addr;
    logic [4:0]  load_value;
    logic        s_valid;
    logic        s_ready;
    logic [2:0]  s_op;
    logic [2:0]  s_op1;
    logic [4:0]  s_op2;
    logic [4:0]  s_delay;
    logic [4:0]  s_side_set;
    logic        s_side_en;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_addr;
    logic [15:0] m_data;
    logic [5:0]  count;
    logic        err_delay;
    logic        err_side;
    logic        err_cfg;

    pio_instr_encoder #(.ADDR_W(5), .INSTR_W(16)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .sideset_bits       (sideset_bits),
        .sideset_enable_bit (sideset_enable_bit),
        .load_addr          (load_addr),
        .load_value         (load_value),
        .s_valid            (s_valid),
        .s_ready            (s_ready),
        .s_op               (s_op),
        .s_op1              (s_op1),
        .s_op2              (s_op2),
        .s_delay            (s_delay),
        .s_side_set         (s_side_set),
        .s_side_en          (s_side_en),
        .m_valid            (m_valid),
        .m_ready            (m_ready),
        .m_addr             (m_addr),
        .m_data             (m_data),
        .count              (count),
        .err_delay          (err_delay),
        .err_side           (err_side),
        .err_cfg            (err_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    bit          mv     = 1'b0;
    int          maddr  = 0;
    int          mcnt   = 0;
    bit          me_d   = 1'b0;
    bit          me_s   = 1'b0;
    bit          me_c   = 1'b0;
    logic [20:0] sb_q[$];

    function automatic bit xe(input bit b);
`ifdef PIO_INSTR_ENCODER_CHECK_EN
        return b;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_word(input int ssb, input int en_bit, input int op, input int op1,
                            input int op2, input int dly, input int side, input int sen,
                            output logic [15:0] w, output bit ed, output bit es, output bit ec);
        int sb, db, en, dw, f;
        sb = (ssb > 5) ? 5 : ssb;
        db = 5 - sb;
        en = (en_bit != 0 && sb != 0) ? 1 : 0;
        dw = sb - en;
        f  = (side % (1 << dw)) * (1 << db) + (dly % (1 << db));
        if (en != 0) f = f + sen * 16;
        w  = 16'(op * 8192 + f * 256 + op1 * 32 + op2);
        ed = dly >= (1 << db);
        es = side >= (1 << dw);
        ec = (en_bit != 0) && (sb == 0);
    endtask

    task automatic set_fields(input int op, input int op1, input int op2,
                              input int dly, input int side, input int sen);
        s_op       = 3'(op);
        s_op1      = 3'(op1);
        s_op2      = 5'(op2);
        s_delay    = 5'(dly);
        s_side_set = 5'(side);
        s_side_en  = 1'(sen);
    endtask

    task automatic step();
        bit          acc, xfer, ed, es, ec;
        logic [15:0] w;
        logic [20:0] front;
        int          a;
        @(negedge clk);
        acc  = s_valid && (!mv || m_ready);
        xfer = mv && m_ready;
        chk("s_ready", 32'(s_ready), 32'(!mv || m_ready));
        if (mv && !m_ready && sb_q.size() > 0) chk("hold", 32'({m_addr, m_data}), 32'(sb_q[0]));
        if (!reset_n) begin
            mv = 1'b0; maddr = 0; mcnt = 0; me_d = 1'b0; me_s = 1'b0; me_c = 1'b0;
            sb_q.delete();
        end else begin
            if (xfer) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $error("FAIL sb_underflow: observed unexpected word 0x%0h expected none", m_data);
                end else begin
                    front = sb_q.pop_front();
                    chk("xfer_word", 32'({m_addr, m_data}), 32'(front));
                end
                if (mcnt < 63) mcnt++;
                mv = 1'b0;
            end
            if (acc) begin
                ref_word(int'(sideset_bits), int'(sideset_enable_bit), int'(s_op), int'(s_op1),
                         int'(s_op2), int'(s_delay), int'(s_side_set), int'(s_side_en),
                         w, ed, es, ec);
                a = load_addr ? int'(load_value) : maddr;
                sb_q.push_back({5'(a), w});
                maddr = (a + 1) % 32;
                me_d |= ed; me_s |= es; me_c |= ec;
                mv = 1'b1;
            end else if (load_addr) begin
                maddr = int'(load_value);
            end
        end
        @(posedge clk);
        #1;
        chk("m_valid", 32'(m_valid), 32'(mv));
        chk("count", 32'(count), 32'(mcnt));
        chk("err_delay", 32'(err_delay), 32'(xe(me_d)));
        chk("err_side", 32'(err_side), 32'(xe(me_s)));
        chk("err_cfg", 32'(err_cfg), 32'(xe(me_c)));
    endtask

    initial begin
        reset_n = 1'b0; sideset_bits = 3'd0; sideset_enable_bit = 1'b0;
        load_addr = 1'b0; load_value = 5'd0; s_valid = 1'b0; m_ready = 1'b1;
        set_fields(0, 0, 0, 0, 0, 0);
        step(); step();
        reset_n = 1'b1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_addr", 32'(m_addr), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_errs", 32'({err_delay, err_side, err_cfg}), 0);

        // JMP, no enable bit
        sideset_bits = 3'd2; sideset_enable_bit = 1'b0;
        set_fields(int'(OP_JMP), 1, 10, 3, 2, 0);
        s_valid = 1'b1; step(); s_valid = 1'b0;
        chk("jmp_latency", 32'(m_valid), 1);
        chk("jmp_data", 32'(m_data), 32'h132A);
        chk("jmp_addr", 32'(m_addr), 0);
        step();

        // MOV with side-set enable
        sideset_enable_bit = 1'b1;
        set_fields(int'(OP_MOV), 0, 0, 7, 1, 1);
        s_valid = 1'b1; step(); s_valid = 1'b0;
        chk("mov_data", 32'(m_data), 32'hBF00);
        chk("mov_addr", 32'(m_addr), 1);
        step();
        chk("mov_noerr", 32'({err_delay, err_side, err_cfg}), 0);

        // delay overflow, sticky across clean words
        sideset_enable_bit = 1'b0;
        set_fields(0, 0, 0, 9, 0, 0);
        s_valid = 1'b1; step(); s_valid = 1'b0;
        chk("ovf_data", 32'(m_data), 32'h0100);
        step();
        chk("ovf_flag", 32'(err_delay), 32'(xe(1'b1)));
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_fields(3, i % 8, i, i % 8, i % 4, 0);
            step();
        end
        s_valid = 1'b0; step();
        chk("ovf_sticky", 32'(err_delay), 32'(xe(1'b1)));

        // load to 31 then wrap
        reset_n = 1'b0; step(); reset_n = 1'b1;
        load_addr = 1'b1; load_value = 5'd31; step(); load_addr = 1'b0;
        set_fields(7, 2, 4, 1, 1, 0);
        s_valid = 1'b1; step();
        chk("load_addr31", 32'(m_addr), 31);
        set_fields(6, 3, 5, 2, 3, 0);
        step(); s_valid = 1'b0;
        chk("wrap_addr0", 32'(m_addr), 0);
        step();
        chk("wrap_count", 32'(count), 2);

        // load in the same cycle as acceptance
        load_addr = 1'b1; load_value = 5'd10; s_valid = 1'b1;
        set_fields(1, 1, 1, 1, 1, 0);
        step(); load_addr = 1'b0;
        chk("load_same_addr", 32'(m_addr), 10);
        set_fields(2, 2, 2, 2, 2, 0);
        step(); s_valid = 1'b0;
        chk("load_next_addr", 32'(m_addr), 11);
        step();

        // backpressure then streaming
        m_ready = 1'b0; s_valid = 1'b1;
        set_fields(4, 5, 17, 6, 3, 0);
        step();
        set_fields(5, 6, 18, 5, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_s_ready", 32'(s_ready), 0);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_fields(i, 7 - i, 3 * i, i, 3 - i, 0);
            step();
        end
        s_valid = 1'b0; step(); step();
        chk("bp_drained", 32'(sb_q.size()), 0);

        // randomised configurations and handshakes
        for (int i = 0; i < 60; i++) begin
            sideset_bits = 3'($urandom_range(0, 7));
            sideset_enable_bit = 1'($urandom_range(0, 1));
            set_fields(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 1)));
            s_valid = 1'($urandom_range(0, 3) != 0);
            m_ready = 1'($urandom_range(0, 3) != 0);
            load_addr = 1'($urandom_range(0, 7) == 0);
            load_value = 5'($urandom_range(0, 31));
            step();
        end
        load_addr = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        step(); step();

        // count saturation
        reset_n = 1'b0; step(); reset_n = 1'b1;
        sideset_bits = 3'd0; sideset_enable_bit = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 70; i++) begin
            set_fields(i % 8, i % 8, i % 32, i % 32, 0, 0);
            step();
        end
        s_valid = 1'b0; step(); step();
        chk("count_sat", 32'(count), 63);

        // reset while a word is held under backpressure
        sideset_bits = 3'd5; m_ready = 1'b0;
        set_fields(2, 1, 1, 1, 0, 0);
        s_valid = 1'b1; step(); s_valid = 1'b0;
        chk("mid_held", 32'(m_valid), 1);
        reset_n = 1'b0; step(); reset_n = 1'b1;
        chk("mid_m_valid", 32'(m_valid), 0);
        chk("mid_count", 32'(count), 0);
        chk("mid_errs", 32'({err_delay, err_side, err_cfg}), 0);
        chk("mid_m_addr", 32'(m_addr), 0);
        m_ready = 1'b1; sideset_bits = 3'd0;
        set_fields(0, 0, 1, 0, 0, 0);
        s_valid = 1'b1; step(); s_valid = 1'b0;
        chk("post_rst_addr", 32'(m_addr), 0);
        step(); step();
        chk("final_drained", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
